sc_microseq: RTL and testbench
==============================

Name: sc_microseq

Overview:
Programmable micro-sequencer for the SC PE-cube array, replacing the fixed-table block controller. Per-step PE-cube config (input pattern, pass-left, clear-acc) comes from a host-loaded microcode table. One start runs a multi-block job with back-to-back blocks and base-relative read/write addressing. The result write-back engine is fully parametrised in FIFO count and group size, and the block pulses done when the job is complete.

Parameters:
ARRAY_NUM, 3, PE arrays per block; pattern lanes
BLOCK_NUM, 3, blocks per cube
CUBE_NUM, 3, cubes; RESULT_NUM = ARRAY_NUM*BLOCK_NUM*CUBE_NUM result FIFOs
RAM_DEPTH, 2048, data RAM words; AW = $clog2(RAM_DEPTH)
SEQ_LEN, 31, microcode steps per block; SW = $clog2(SEQ_LEN)
ADDR_STEP, 4, address increment per read step and per write beat
FIFO_GROUP, 4, result FIFOs popped per write beat; WR_BEATS = ceil(RESULT_NUM/FIFO_GROUP); BW = max(1,$clog2(WR_BEATS))

Ports:
iClk  in  1  clock
iRstN  in  1  asynchronous active-low reset
iCfgWe  in  1  microcode write; honoured only while oReady=1
iCfgAddr  in  SW  microcode entry index; writes with index >= SEQ_LEN are ignored
iCfgData  in  UW=4*ARRAY_NUM  entry {clearAcc[1], passLeft[ARRAY_NUM-1], pattern[3*ARRAY_NUM]}
iStart  in  1  job start; honoured only while oReady=1
iBlockCount  in  16  blocks in job, latched at start
iRdBase  in  AW  read base, latched at start
iWrBase  in  AW  write base, latched at start
oReady  out  1  idle; accepts start and config
oDone  out  1  one-cycle job-complete pulse
oClearAcc  out  1  PE accumulator clear
oInputPattern  out  3*ARRAY_NUM  per-lane pattern select
oPassDataLeft  out  ARRAY_NUM-1  per-lane pass-left
oDataRdValid  out  1  read data valid, one cycle after address
oAddrRd  out  AW  RAM read address
iAllResultFifoHasData  in  1  every result FIFO holds at least one entry
oResultRdEn  out  RESULT_NUM  result FIFO pops
oWriteEn  out  1  RAM write strobe
oAddrWr  out  AW  RAM write address
oResultFifoSel  out  BW  write-data mux select (beat index)

Behaviour:
- Reset (async assert; deassert synchronised by the flop network): all outputs 0, except oReady=1 and each oInputPattern lane=3'd5 (NOT_CARE). Microcode table is cleared to 0.
- Config: when iCfgWe=1 and oReady=1, table[iCfgAddr] <= iCfgData on the next edge.
- Read FSM:
  - RD_IDLE -> RD_RUN on iStart and oReady. On that edge: latch count/bases, set step=0, blk=0.
  - iBlockCount=0: no RD_RUN. oDone pulses the cycle after start, and oReady returns 1 that same cycle.
  - RD_RUN: step increments each cycle. When step=SEQ_LEN-1: if blk=count-1 go to RD_IDLE, else blk++ and step=0 with no gap cycle.
- Read address: oAddrRd = (rdBase + (blk*SEQ_LEN + step)*ADDR_STEP) mod RAM_DEPTH. It is combinational from the registers and valid while in RD_RUN.
- oDataRdValid = registered (state==RD_RUN).
- Config outputs: registered table[step] while in RD_RUN, i.e. one cycle after the step is presented. Outside RD_RUN the registered values are clearAcc=0, passLeft=0, pattern=NOT_CARE.
- Write FSM:
  - WR_IDLE -> WR_BURST when iAllResultFifoHasData=1, a job is active and wrBlk < count.
  - WR_BURST: beat counter b runs 0..WR_BEATS-1, then returns to WR_IDLE and wrBlk++.
  - Has-data is sampled only in WR_IDLE.
  - Data arriving before the read side finishes is legal.
- Write pipeline timing, for beat b at cycle t:
  - t+1: oResultRdEn = mask with bits [b*FIFO_GROUP, min((b+1)*FIFO_GROUP, RESULT_NUM)) set; 0 in every other cycle.
  - t+2: oWriteEn=1 and oResultFifoSel=b. oResultFifoSel=0 when oWriteEn=0.
- Write address: oAddrWr = wrBase at job start. It advances by ADDR_STEP the cycle after each oWriteEn and wraps mod RAM_DEPTH.
- oDone: pulses the cycle after the final oWriteEn of block count-1. oReady=1 in that same cycle.
- oReady=1 only when both FSMs are idle and no job is active. It deasserts the cycle after an accepted start.
- While busy, iStart and iCfgWe are ignored. Latched job parameters hold through the job.
- Reset mid-job: immediate abort. Outputs return to their reset values and the table is cleared.

Test Plan:
1. Load table[s].pattern = s[8:0], clearAcc at s=27 only; start with count=1, rdBase=0. Required: oAddrRd=0,4,...,120 over 31 cycles; oInputPattern=s one cycle later; oClearAcc high exactly once; oDataRdValid high for 31 cycles.
2. count=3, rdBase=2040. Required: 93 contiguous RD_RUN cycles with no gap; oAddrRd wraps 2044 -> 0.
3. Hold has-data=1 from start with count=1, wrBase=100. Required: 7 oResultRdEn masks 27'h000000F ... 27'h0F00000 then 27'h7000000; oWriteEn for 7 cycles with sel=0..6; oAddrWr=100..124; oDone one cycle after last oWriteEn, with oReady=1 that cycle.
4. count=2 with has-data pulsed late. Required: second burst starts only after has-data is sampled in WR_IDLE; exactly 14 oWriteEn in total; one oDone.
5. iStart and iCfgWe asserted mid-job. Required: both ignored and table unchanged. count=0 start: required oDone the next cycle and no reads.
6. Drop iRstN mid-burst. Required: oWriteEn, oResultRdEn and oDone are 0 immediately; oReady=1; table reads back zeros.

Source files
------------

// File: rtl/sc_microseq_if.sv
// rtl/sc_microseq_if.sv - host config, RAM address and result-FIFO signal bundle of the SC micro-sequencer
interface sc_microseq_if #(
  parameter int ARRAY_NUM  = 3,
  parameter int BLOCK_NUM  = 3,
  parameter int CUBE_NUM   = 3,
  parameter int RAM_DEPTH  = 2048,
  parameter int SEQ_LEN    = 31,
  parameter int FIFO_GROUP = 4
);
  localparam int RESULT_NUM = ARRAY_NUM * BLOCK_NUM * CUBE_NUM;
  localparam int AW         = $clog2(RAM_DEPTH);
  localparam int SW         = $clog2(SEQ_LEN);
  localparam int UW         = 4 * ARRAY_NUM;
  localparam int WR_BEATS   = (RESULT_NUM + FIFO_GROUP - 1) / FIFO_GROUP;
  localparam int BW         = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;

  logic                   iCfgWe;
  logic [SW-1:0]          iCfgAddr;
  logic [UW-1:0]          iCfgData;
  logic                   iStart;
  logic [15:0]            iBlockCount;
  logic [AW-1:0]          iRdBase;
  logic [AW-1:0]          iWrBase;
  logic                   oReady;
  logic                   oDone;
  logic                   oClearAcc;
  logic [3*ARRAY_NUM-1:0] oInputPattern;
  logic [ARRAY_NUM-2:0]   oPassDataLeft;
  logic                   oDataRdValid;
  logic [AW-1:0]          oAddrRd;
  logic                   iAllResultFifoHasData;
  logic [RESULT_NUM-1:0]  oResultRdEn;
  logic                   oWriteEn;
  logic [AW-1:0]          oAddrWr;
  logic [BW-1:0]          oResultFifoSel;

  modport slave (
    input  iCfgWe, iCfgAddr, iCfgData, iStart, iBlockCount, iRdBase, iWrBase,
           iAllResultFifoHasData,
    output oReady, oDone, oClearAcc, oInputPattern, oPassDataLeft, oDataRdValid,
           oAddrRd, oResultRdEn, oWriteEn, oAddrWr, oResultFifoSel
  );

  modport master (
    output iCfgWe, iCfgAddr, iCfgData, iStart, iBlockCount, iRdBase, iWrBase,
           iAllResultFifoHasData,
    input  oReady, oDone, oClearAcc, oInputPattern, oPassDataLeft, oDataRdValid,
           oAddrRd, oResultRdEn, oWriteEn, oAddrWr, oResultFifoSel
  );
endinterface

// File: rtl/sc_microseq.sv
// rtl/sc_microseq.sv - microcoded multi-block job sequencer for the SC PE-cube array
// Read side steps the microcode table per block; write side drains result FIFOs in grouped beats.
module sc_microseq #(
  parameter int ARRAY_NUM  = 3,
  parameter int BLOCK_NUM  = 3,
  parameter int CUBE_NUM   = 3,
  parameter int RAM_DEPTH  = 2048,
  parameter int SEQ_LEN    = 31,
  parameter int ADDR_STEP  = 4,
  parameter int FIFO_GROUP = 4
) (
  input logic         iClk,
  input logic         iRstN,
  sc_microseq_if.slave bus
);
  localparam int RESULT_NUM = ARRAY_NUM * BLOCK_NUM * CUBE_NUM;
  localparam int AW         = $clog2(RAM_DEPTH);
  localparam int SW         = $clog2(SEQ_LEN);
  localparam int UW         = 4 * ARRAY_NUM;
  localparam int WR_BEATS   = (RESULT_NUM + FIFO_GROUP - 1) / FIFO_GROUP;
  localparam int BW         = (WR_BEATS > 1) ? $clog2(WR_BEATS) : 1;
  localparam logic [3*ARRAY_NUM-1:0] PAT_IDLE = {ARRAY_NUM{3'd5}};

  typedef enum logic {RD_IDLE, RD_RUN} rd_state_e;
  typedef enum logic {WR_IDLE, WR_BURST} wr_state_e;

  rd_state_e              rd_state_q, rd_state_d;
  wr_state_e              wr_state_q, wr_state_d;
  logic                   job_q, job_d;
  logic [15:0]            count_q, count_d, blk_q, blk_d, wr_blk_q, wr_blk_d;
  logic [SW-1:0]          step_q, step_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [BW-1:0]          beat_q, beat_d, pop_beat_q, pop_beat_d, sel_q, sel_d;
  logic                   pop_v_q, pop_v_d, we_q, we_d, done_q, done_d;
  logic                   rd_valid_q, rd_valid_d, clear_q, clear_d;
  logic [RESULT_NUM-1:0]  rd_en_q, rd_en_d;
  logic [ARRAY_NUM-2:0]   pass_q, pass_d;
  logic [3*ARRAY_NUM-1:0] pat_q, pat_d;
  logic [UW-1:0]          table_q [SEQ_LEN];
  logic [UW-1:0]          table_d [SEQ_LEN];
  logic                   ready, final_burst;

  function automatic logic [RESULT_NUM-1:0] beat_mask(input logic [BW-1:0] b);
    logic [RESULT_NUM-1:0] m;
    for (int i = 0; i < RESULT_NUM; i++)
      m[i] = (i >= int'(b) * FIFO_GROUP) && (i < (int'(b) + 1) * FIFO_GROUP);
    return m;
  endfunction

  assign ready       = (rd_state_q == RD_IDLE) && (wr_state_q == WR_IDLE) && !job_q;
  // The last block's burst waits for the reads so done always means both sides are idle.
  assign final_burst = (wr_blk_q == count_q - 16'd1);

  always_comb begin
    rd_state_d = rd_state_q;
    wr_state_d = wr_state_q;
    job_d      = job_q;
    count_d    = count_q;
    blk_d      = blk_q;
    wr_blk_d   = wr_blk_q;
    step_d     = step_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    beat_d     = beat_q;
    table_d    = table_q;
    done_d     = 1'b0;
    rd_valid_d = (rd_state_q == RD_RUN);
    rd_en_d    = (wr_state_q == WR_BURST) ? beat_mask(beat_q) : '0;
    pop_v_d    = (wr_state_q == WR_BURST);
    pop_beat_d = beat_q;
    we_d       = pop_v_q;
    sel_d      = pop_v_q ? pop_beat_q : '0;
    clear_d    = 1'b0;
    pass_d     = '0;
    pat_d      = PAT_IDLE;

    if (ready && bus.iCfgWe && (int'(bus.iCfgAddr) < SEQ_LEN))
      table_d[bus.iCfgAddr] = bus.iCfgData;

    if (we_q)
      wr_ptr_d = wr_ptr_q + AW'(ADDR_STEP);

    if (ready && bus.iStart) begin
      count_d  = bus.iBlockCount;
      rd_ptr_d = bus.iRdBase;
      wr_ptr_d = bus.iWrBase;
      step_d   = '0;
      blk_d    = '0;
      wr_blk_d = '0;
      if (bus.iBlockCount == 16'd0) begin
        done_d = 1'b1;
      end else begin
        job_d      = 1'b1;
        rd_state_d = RD_RUN;
      end
    end

    if (rd_state_q == RD_RUN) begin
      {clear_d, pass_d, pat_d} = table_q[step_q];
      rd_ptr_d = rd_ptr_q + AW'(ADDR_STEP);
      if (step_q == SW'(SEQ_LEN - 1)) begin
        step_d = '0;
        if (blk_q == count_q - 16'd1) rd_state_d = RD_IDLE;
        else                          blk_d      = blk_q + 16'd1;
      end else begin
        step_d = step_q + SW'(1);
      end
    end

    case (wr_state_q)
      WR_IDLE: begin
        if (bus.iAllResultFifoHasData && job_q && (wr_blk_q < count_q) &&
            (!final_burst || rd_state_q == RD_IDLE)) begin
          wr_state_d = WR_BURST;
          beat_d     = '0;
        end
      end
      WR_BURST: begin
        if (beat_q == BW'(WR_BEATS - 1)) begin
          wr_state_d = WR_IDLE;
          beat_d     = '0;
          wr_blk_d   = wr_blk_q + 16'd1;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      default: wr_state_d = WR_IDLE;
    endcase

    // wr_blk has already advanced past the final block by the time its last beat is written.
    if (job_q && we_q && (sel_q == BW'(WR_BEATS - 1)) && (wr_blk_q == count_q)) begin
      done_d = 1'b1;
      job_d  = 1'b0;
    end
  end

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      rd_state_q <= RD_IDLE;
      wr_state_q <= WR_IDLE;
      job_q      <= 1'b0;
      count_q    <= '0;
      blk_q      <= '0;
      wr_blk_q   <= '0;
      step_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      beat_q     <= '0;
      pop_beat_q <= '0;
      sel_q      <= '0;
      pop_v_q    <= 1'b0;
      we_q       <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_en_q    <= '0;
      clear_q    <= 1'b0;
      pass_q     <= '0;
      pat_q      <= PAT_IDLE;
      for (int i = 0; i < SEQ_LEN; i++) table_q[i] <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      wr_state_q <= wr_state_d;
      job_q      <= job_d;
      count_q    <= count_d;
      blk_q      <= blk_d;
      wr_blk_q   <= wr_blk_d;
      step_q     <= step_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      beat_q     <= beat_d;
      pop_beat_q <= pop_beat_d;
      sel_q      <= sel_d;
      pop_v_q    <= pop_v_d;
      we_q       <= we_d;
      done_q     <= done_d;
      rd_valid_q <= rd_valid_d;
      rd_en_q    <= rd_en_d;
      clear_q    <= clear_d;
      pass_q     <= pass_d;
      pat_q      <= pat_d;
      table_q    <= table_d;
    end
  end

  assign bus.oReady         = ready;
  assign bus.oDone          = done_q;
  assign bus.oClearAcc      = clear_q;
  assign bus.oInputPattern  = pat_q;
  assign bus.oPassDataLeft  = pass_q;
  assign bus.oDataRdValid   = rd_valid_q;
  assign bus.oAddrRd        = (rd_state_q == RD_RUN) ? rd_ptr_q : '0;
  assign bus.oResultRdEn    = rd_en_q;
  assign bus.oWriteEn       = we_q;
  assign bus.oAddrWr        = wr_ptr_q;
  assign bus.oResultFifoSel = sel_q;
endmodule

// File: tb/tb_sc_microseq.sv
// tb/tb_sc_microseq.sv - directed-vector bench for sc_microseq
module tb_sc_microseq;
  logic iClk = 1'b0;
  logic iRstN = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  localparam logic [8:0] PAT_IDLE = 9'h16D;
  logic [26:0] masks [7] = '{27'h000000F, 27'h00000F0, 27'h0000F00, 27'h000F000,
                             27'h00F0000, 27'h0F00000, 27'h7000000};

  sc_microseq_if u_if ();
  sc_microseq dut (.iClk(iClk), .iRstN(iRstN), .bus(u_if.slave));

  always #5 iClk = ~iClk;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic start_job(input logic [15:0] cnt, input logic [10:0] rb, input logic [10:0] wb);
    u_if.iStart = 1'b1; u_if.iBlockCount = cnt; u_if.iRdBase = rb; u_if.iWrBase = wb;
    tick();
    u_if.iStart = 1'b0;
  endtask

  task automatic finish_job();
    bit seen = 0;
    u_if.iAllResultFifoHasData = 1'b1;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick();
      if (u_if.oDone) seen = 1;
    end
    u_if.iAllResultFifoHasData = 1'b0;
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL finish_job: oDone not seen within 400 cycles"); end
  endtask

  task automatic test_reset();
    iRstN = 1'b0;
    tick(); tick();
    vectors += 4;
    if (u_if.oReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", u_if.oReady); end
    if (u_if.oInputPattern !== PAT_IDLE) begin miscompares++; $display("FAIL reset_pattern: got %h want %h", u_if.oInputPattern, PAT_IDLE); end
    if ({u_if.oDone, u_if.oWriteEn, u_if.oDataRdValid, u_if.oClearAcc} !== 4'b0) begin miscompares++; $display("FAIL reset_strobes: got %b want 0", {u_if.oDone, u_if.oWriteEn, u_if.oDataRdValid, u_if.oClearAcc}); end
    if (u_if.oResultRdEn !== 27'h0 || u_if.oAddrRd !== 11'd0) begin miscompares++; $display("FAIL reset_bus: rden %h addr %0d want 0", u_if.oResultRdEn, u_if.oAddrRd); end
    iRstN = 1'b1;
    tick();
  endtask

  task automatic test_pattern();
    int clears = 0;
    for (int s = 0; s < 31; s++) begin
      logic [4:0] s5 = 5'(s);
      u_if.iCfgWe = 1'b1; u_if.iCfgAddr = s5;
      u_if.iCfgData = {(s == 27) ? 1'b1 : 1'b0, s5[1:0], 9'(s)};
      tick();
    end
    u_if.iCfgWe = 1'b0;
    start_job(16'd1, 11'd0, 11'd0);
    vectors++;
    if (u_if.oReady !== 1'b0) begin miscompares++; $display("FAIL pattern_busy: oReady %b want 0", u_if.oReady); end
    for (int s = 0; s < 31; s++) begin
      logic [4:0] s5 = 5'(s);
      vectors++;
      if (u_if.oAddrRd !== 11'(s * 4)) begin miscompares++; $display("FAIL pattern_addr step %0d: got %0d want %0d", s, u_if.oAddrRd, s * 4); end
      tick();
      vectors++;
      if (u_if.oInputPattern !== 9'(s) || u_if.oPassDataLeft !== s5[1:0] || u_if.oDataRdValid !== 1'b1) begin
        miscompares++;
        $display("FAIL pattern_cfg step %0d: pat %0d pass %0d vld %b want %0d %0d 1", s, u_if.oInputPattern, u_if.oPassDataLeft, u_if.oDataRdValid, s, s5[1:0]);
      end
      if (u_if.oClearAcc) clears++;
    end
    tick();
    vectors += 2;
    if (clears !== 1) begin miscompares++; $display("FAIL pattern_clear_count: got %0d want 1", clears); end
    if (u_if.oDataRdValid !== 1'b0 || u_if.oInputPattern !== PAT_IDLE) begin miscompares++; $display("FAIL pattern_end: vld %b pat %h want 0 %h", u_if.oDataRdValid, u_if.oInputPattern, PAT_IDLE); end
    finish_job();
  endtask

  task automatic test_wrap();
    start_job(16'd3, 11'd2040, 11'd0);
    for (int k = 0; k < 93; k++) begin
      vectors++;
      if (u_if.oAddrRd !== 11'((2040 + 4 * k) % 2048)) begin miscompares++; $display("FAIL wrap_addr %0d: got %0d want %0d", k, u_if.oAddrRd, (2040 + 4 * k) % 2048); end
      tick();
      vectors++;
      if (u_if.oDataRdValid !== 1'b1) begin miscompares++; $display("FAIL wrap_gap %0d: vld %b want 1", k, u_if.oDataRdValid); end
    end
    tick();
    vectors++;
    if (u_if.oDataRdValid !== 1'b0) begin miscompares++; $display("FAIL wrap_end: vld %b want 0", u_if.oDataRdValid); end
    finish_job();
  endtask

  task automatic test_write();
    bit found = 0;
    u_if.iAllResultFifoHasData = 1'b1;
    start_job(16'd1, 11'd0, 11'd100);
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (u_if.oResultRdEn !== 27'h0) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL write_start: no oResultRdEn within 100 cycles"); end
    for (int j = 0; j < 9; j++) begin
      logic [26:0] exp_en = (j < 7) ? masks[j] : 27'h0;
      logic        exp_we = (j >= 1 && j <= 7);
      logic [2:0]  exp_sel = exp_we ? 3'(j - 1) : 3'd0;
      vectors += 3;
      if (u_if.oResultRdEn !== exp_en) begin miscompares++; $display("FAIL write_rden %0d: got %h want %h", j, u_if.oResultRdEn, exp_en); end
      if (u_if.oWriteEn !== exp_we || u_if.oResultFifoSel !== exp_sel) begin miscompares++; $display("FAIL write_we %0d: we %b sel %0d want %b %0d", j, u_if.oWriteEn, u_if.oResultFifoSel, exp_we, exp_sel); end
      if (u_if.oDone !== (j == 8) || (j == 8 && u_if.oReady !== 1'b1)) begin miscompares++; $display("FAIL write_done %0d: done %b ready %b", j, u_if.oDone, u_if.oReady); end
      if (exp_we) begin
        vectors++;
        if (u_if.oAddrWr !== 11'(100 + 4 * (j - 1))) begin miscompares++; $display("FAIL write_addr %0d: got %0d want %0d", j, u_if.oAddrWr, 100 + 4 * (j - 1)); end
      end
      if (j < 8) tick();
    end
    u_if.iAllResultFifoHasData = 1'b0;
    tick();
    vectors++;
    if (u_if.oDone !== 1'b0) begin miscompares++; $display("FAIL write_done_pulse: done %b want 0", u_if.oDone); end
  endtask

  task automatic test_back_to_back();
    int we_total = 0, we_before = 0, dones = 0;
    start_job(16'd2, 11'd0, 11'd0);
    for (int i = 0; i < 200; i++) begin
      u_if.iAllResultFifoHasData = (i == 10 || i == 13 || i == 80);
      tick();
      if (u_if.oWriteEn) begin we_total++; if (i < 80) we_before++; end
      if (u_if.oDone) dones++;
    end
    u_if.iAllResultFifoHasData = 1'b0;
    vectors += 4;
    if (we_before !== 7) begin miscompares++; $display("FAIL late_first_burst: got %0d writes want 7", we_before); end
    if (we_total !== 14) begin miscompares++; $display("FAIL late_total_writes: got %0d want 14", we_total); end
    if (dones !== 1) begin miscompares++; $display("FAIL late_done_count: got %0d want 1", dones); end
    if (u_if.oReady !== 1'b1) begin miscompares++; $display("FAIL late_ready: got %b want 1", u_if.oReady); end
  endtask

  task automatic test_ignore();
    start_job(16'd1, 11'd0, 11'd0);
    for (int k = 0; k < 31; k++) begin
      u_if.iCfgWe = (k == 2); u_if.iCfgAddr = 5'd5; u_if.iCfgData = 12'hFFF;
      u_if.iStart = (k == 2); u_if.iBlockCount = 16'd5;
      tick();
      if (k == 5) begin
        vectors++;
        if (u_if.oInputPattern !== 9'd5 || u_if.oClearAcc !== 1'b0) begin miscompares++; $display("FAIL ignore_cfg: pat %0d clr %b want 5 0", u_if.oInputPattern, u_if.oClearAcc); end
      end
    end
    u_if.iCfgWe = 1'b0; u_if.iStart = 1'b0;
    tick();
    vectors++;
    if (u_if.oDataRdValid !== 1'b0) begin miscompares++; $display("FAIL ignore_start: vld %b want 0", u_if.oDataRdValid); end
    finish_job();
    start_job(16'd0, 11'd0, 11'd0);
    vectors += 2;
    if (u_if.oDone !== 1'b1 || u_if.oReady !== 1'b1) begin miscompares++; $display("FAIL zero_done: done %b ready %b want 1 1", u_if.oDone, u_if.oReady); end
    if (u_if.oDataRdValid !== 1'b0) begin miscompares++; $display("FAIL zero_read: vld %b want 0", u_if.oDataRdValid); end
    tick();
    vectors++;
    if (u_if.oDone !== 1'b0 || u_if.oDataRdValid !== 1'b0) begin miscompares++; $display("FAIL zero_after: done %b vld %b want 0 0", u_if.oDone, u_if.oDataRdValid); end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    u_if.iAllResultFifoHasData = 1'b1;
    start_job(16'd1, 11'd0, 11'd0);
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (u_if.oWriteEn) found = 1;
    end
    vectors++;
    if (!found) begin miscompares++; $display("FAIL abort_wait: no oWriteEn within 100 cycles"); end
    #2 iRstN = 1'b0;
    #1;
    vectors += 2;
    if ({u_if.oWriteEn, u_if.oDone} !== 2'b0 || u_if.oResultRdEn !== 27'h0) begin miscompares++; $display("FAIL abort_strobes: we %b done %b rden %h want 0", u_if.oWriteEn, u_if.oDone, u_if.oResultRdEn); end
    if (u_if.oReady !== 1'b1 || u_if.oInputPattern !== PAT_IDLE) begin miscompares++; $display("FAIL abort_idle: ready %b pat %h want 1 %h", u_if.oReady, u_if.oInputPattern, PAT_IDLE); end
    u_if.iAllResultFifoHasData = 1'b0;
    tick();
    iRstN = 1'b1;
    tick();
    start_job(16'd1, 11'd0, 11'd0);
    for (int k = 0; k < 31; k++) begin
      tick();
      vectors++;
      if (u_if.oInputPattern !== 9'd0 || u_if.oPassDataLeft !== 2'd0 || u_if.oClearAcc !== 1'b0) begin
        miscompares++;
        $display("FAIL abort_table %0d: pat %h pass %0d clr %b want 0", k, u_if.oInputPattern, u_if.oPassDataLeft, u_if.oClearAcc);
      end
    end
    finish_job();
  endtask

  initial begin
    u_if.iCfgWe = 1'b0; u_if.iCfgAddr = '0; u_if.iCfgData = '0;
    u_if.iStart = 1'b0; u_if.iBlockCount = '0; u_if.iRdBase = '0; u_if.iWrBase = '0;
    u_if.iAllResultFifoHasData = 1'b0;
    test_reset();
    test_pattern();
    test_wrap();
    test_write();
    test_back_to_back();
    test_ignore();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
